// File: rtl/spi_slave_engine.sv
// spi_slave_engine: SPI responder bit engine between SPI pads and TX/RX FIFOs.
//   Synchronises SCK/SS/MOSI into CLK, detects SCK edges per CPOL/CPHA, shifts one
//   WORD_W word per frame, pops the TX FIFO and pushes the RX FIFO. Needs CLK >= 8x SCK.
//   Build option: SPI_SLV_LSB_FIRST_EN selects LSB-first shifting (default MSB-first).
// Ports:
//   CLK, nRST            system clock (rising), asynchronous active-low reset
//   EN                   engine enable; low aborts to IDLE
//   CPOL, CPHA           SPI mode, latched at frame start
//   SCK_IN, SS_IN, MOSI_IN  asynchronous pad inputs (SS active-low)
//   MISO_OUT, MISO_OE    serial data out and pad enable (enable high while not IDLE)
//   TX_EMPTY, TX_DATA, TX_REN  first-word-fall-through TX FIFO head and pop
//   RX_FULL, RX_DATA, RX_WEN   RX FIFO status, word and push
//   ERR_CLR              clears UNDERRUN/OVERRUN
//   ACTIVE               frame in progress
//   UNDERRUN, OVERRUN    sticky: load with TX empty / word completed with RX full
module spi_slave_engine #(
  parameter int WORD_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              EN,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic              SCK_IN,
  input  logic              SS_IN,
  input  logic              MOSI_IN,
  output logic              MISO_OUT,
  output logic              MISO_OE,
  input  logic              TX_EMPTY,
  input  logic [WORD_W-1:0] TX_DATA,
  output logic              TX_REN,
  input  logic              RX_FULL,
  output logic [WORD_W-1:0] RX_DATA,
  output logic              RX_WEN,
  input  logic              ERR_CLR,
  output logic              ACTIVE,
  output logic              UNDERRUN,
  output logic              OVERRUN
);
  localparam int CW = $clog2(WORD_W + 1);
  typedef enum logic [1:0] {IDLE, LOAD, XFER, DONE} state_t;
  state_t state_q;
  logic [SYNC_STAGES-1:0] sck_q, ss_q, mosi_q;
  logic sck_p_q, ss_p_q, cpol_q, cpha_q, rx_wen_q, und_q, ovr_q;
  logic [WORD_W-1:0] tx_q, rx_q, rx_data_q, tx_sh, rx_in;
  logic [CW-1:0] cnt_q;
  logic sck_s, ss_s, mosi_s, rise, fall, smp, shf, last, ss_fall, load;
  assign sck_s   = sck_q[SYNC_STAGES-1];
  assign ss_s    = ss_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_q[SYNC_STAGES-1];
  assign rise    = sck_s & ~sck_p_q;
  assign fall    = ~sck_s & sck_p_q;
  // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling edge.
  assign smp     = (cpol_q ^ cpha_q) ? fall : rise;
  assign shf     = (cpol_q ^ cpha_q) ? rise : fall;
  assign last    = smp && (cnt_q == CW'(WORD_W - 1));
  assign ss_fall = ss_p_q & ~ss_s;
  // A word is fetched at frame start and again at each word end while SS stays low.
  assign load    = EN && !ss_s && (state_q == LOAD || state_q == DONE);
  assign TX_REN  = load && !TX_EMPTY;
  assign MISO_OE = state_q != IDLE;
  assign ACTIVE  = state_q != IDLE;
  assign RX_DATA  = rx_data_q;
  assign RX_WEN   = rx_wen_q;
  assign UNDERRUN = und_q;
  assign OVERRUN  = ovr_q;
`ifdef SPI_SLV_LSB_FIRST_EN
  assign MISO_OUT = tx_q[0];
  assign tx_sh    = tx_q >> 1;
  assign rx_in    = {mosi_s, rx_q[WORD_W-1:1]};
`else
  assign MISO_OUT = tx_q[WORD_W-1];
  assign tx_sh    = tx_q << 1;
  assign rx_in    = {rx_q[WORD_W-2:0], mosi_s};
`endif
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      sck_q     <= '0;
      ss_q      <= '1;
      mosi_q    <= '0;
      sck_p_q   <= 1'b0;
      ss_p_q    <= 1'b1;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      cnt_q     <= '0;
      rx_wen_q  <= 1'b0;
      und_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sck_q    <= {sck_q[SYNC_STAGES-2:0], SCK_IN};
      ss_q     <= {ss_q[SYNC_STAGES-2:0], SS_IN};
      mosi_q   <= {mosi_q[SYNC_STAGES-2:0], MOSI_IN};
      sck_p_q  <= sck_s;
      ss_p_q   <= ss_s;
      rx_wen_q <= 1'b0;
      und_q    <= und_q & ~ERR_CLR;
      ovr_q    <= ovr_q & ~ERR_CLR;
      if (!EN) state_q <= IDLE;
      else case (state_q)
        IDLE: if (ss_fall) begin
          cpol_q  <= CPOL;
          cpha_q  <= CPHA;
          state_q <= LOAD;
        end
        LOAD: begin
          cnt_q   <= '0;
          state_q <= ss_s ? IDLE : XFER;
        end
        XFER: begin
          if (smp) begin
            rx_q  <= rx_in;
            cnt_q <= cnt_q + CW'(1);
          end
          // The first bit must stay on MISO until it has been sampled.
          if (shf && cnt_q != '0) tx_q <= tx_sh;
          // A completed word wins over a simultaneous SS release.
          if (last) state_q <= DONE;
          else if (ss_s) state_q <= IDLE;
        end
        DONE: begin
          rx_data_q <= rx_q;
          rx_wen_q  <= !RX_FULL;
          if (RX_FULL) ovr_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ss_s ? IDLE : XFER;
        end
      endcase
      if (load) begin
        tx_q <= TX_EMPTY ? '0 : TX_DATA;
        if (TX_EMPTY) und_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_engine.sv
// tb_spi_slave_engine: directed SPI master stimulus with hand-computed expectations.
module tb_spi_slave_engine;
  logic clk = 0, nrst = 0, en = 1, cpol = 0, cpha = 0, sck = 0, ss = 1, mosi = 0;
  logic miso, miso_oe, tx_ren, rx_wen, active, underrun, overrun, rx_full = 0, err_clr = 0;
  logic [7:0] rx_data, tx_data;
  logic tx_empty;
  logic [7:0] tx_mem [4];
  logic [7:0] rx_log [16];
  int pops = 0, pushes = 0, p0 = 0, q0 = 0, tx_n = 0;
  int n_chk = 0, n_err = 0;
  logic [15:0] mi;
  logic oe;
  always #5 clk = ~clk;
  assign tx_data  = tx_mem[2'(pops - p0)];
  assign tx_empty = (pops - p0) >= tx_n;
  spi_slave_engine dut (
    .CLK(clk), .nRST(nrst), .EN(en), .CPOL(cpol), .CPHA(cpha),
    .SCK_IN(sck), .SS_IN(ss), .MOSI_IN(mosi), .MISO_OUT(miso), .MISO_OE(miso_oe),
    .TX_EMPTY(tx_empty), .TX_DATA(tx_data), .TX_REN(tx_ren),
    .RX_FULL(rx_full), .RX_DATA(rx_data), .RX_WEN(rx_wen),
    .ERR_CLR(err_clr), .ACTIVE(active), .UNDERRUN(underrun), .OVERRUN(overrun)
  );
  always @(posedge clk) begin
    if (tx_ren) pops <= pops + 1;
    if (rx_wen) begin
      rx_log[4'(pushes)] <= rx_data;
      pushes <= pushes + 1;
    end
  end
  function automatic logic [7:0] ord(input logic [7:0] x);
`ifdef SPI_SLV_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) ord[i] = x[7-i];
`else
    ord = x;
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic hw;
    cyc(4);
  endtask
  task automatic start(input logic [7:0] a, input logic [7:0] b, input int n);
    tx_mem[0] = a;
    tx_mem[1] = b;
    tx_n = n;
    p0 = pops;
    q0 = pushes;
  endtask
  task automatic frame(input logic pol, input logic pha, input int nb, input logic [15:0] mo,
                       input bit ss_last, output logic [15:0] m, output logic o);
    m = 0;
    cpol = pol;
    cpha = pha;
    sck = pol;
    hw();
    ss = 0;
    if (!pha) mosi = mo[nb-1];
    hw();
    o = miso_oe;
    hw();
    for (int i = 0; i < nb; i++) begin
      sck = ~pol;
      if (pha) mosi = mo[nb-1-i];
      else m = {m[14:0], miso};
      if (!pha && i == nb - 1 && ss_last) ss = 1;
      hw();
      sck = pol;
      if (pha) m = {m[14:0], miso};
      else if (i < nb - 1) mosi = mo[nb-2-i];
      if (pha && i == nb - 1 && ss_last) ss = 1;
      hw();
    end
    if (!ss_last) ss = 1;
  endtask
  initial begin
    tx_mem = '{default: 8'h00};
    cyc(3);
    chk("reset_ctl", {miso, miso_oe, tx_ren, rx_wen, active, underrun, overrun}, 0);
    chk("reset_rxdata", rx_data, 0);
    nrst = 1;
    cyc(3);
    start(8'hA5, 8'h00, 1);
    frame(0, 0, 8, 16'h003C, 1, mi, oe);
    cyc(4);
    chk("m0_oe", oe, 1);
    chk("m0_miso", mi, {8'h00, ord(8'hA5)});
    chk("m0_pushes", pushes - q0, 1);
    chk("m0_rx", rx_log[4'(q0)], ord(8'h3C));
    chk("m0_pops", pops - p0, 1);
    chk("m0_idle", {active, underrun, overrun}, 0);
    start(8'h12, 8'h34, 2);
    frame(1, 1, 16, 16'hF00F, 1, mi, oe);
    cyc(4);
    chk("m3_miso", mi, {ord(8'h12), ord(8'h34)});
    chk("m3_pushes", pushes - q0, 2);
    chk("m3_rx0", rx_log[4'(q0)], ord(8'hF0));
    chk("m3_rx1", rx_log[4'(q0 + 1)], ord(8'h0F));
    chk("m3_pops", pops - p0, 2);
    start(8'h00, 8'h00, 0);
    frame(0, 0, 8, 16'h0055, 1, mi, oe);
    cyc(4);
    chk("und_miso", mi, 0);
    chk("und_rx", rx_log[4'(q0)], ord(8'h55));
    chk("und_flag", underrun, 1);
    cyc(3);
    chk("und_sticky", underrun, 1);
    err_clr = 1;
    cyc(1);
    err_clr = 0;
    chk("und_clr", underrun, 0);
    start(8'hA5, 8'h00, 1);
    rx_full = 1;
    frame(0, 0, 8, 16'h0081, 1, mi, oe);
    cyc(4);
    rx_full = 0;
    chk("ovr_miso", mi, {8'h00, ord(8'hA5)});
    chk("ovr_pushes", pushes - q0, 0);
    chk("ovr_flag", {overrun, underrun}, 2'b10);
    err_clr = 1;
    cyc(1);
    err_clr = 0;
    chk("ovr_clr", overrun, 0);
    start(8'hA5, 8'h00, 1);
    frame(0, 0, 5, 16'h0016, 0, mi, oe);
    cyc(4);
    chk("abort_idle", active, 0);
    chk("abort_pushes", pushes - q0, 0);
    chk("abort_miso", mi, 16'h0014);
    start(8'h5A, 8'h00, 1);
    frame(0, 0, 8, 16'h00C3, 1, mi, oe);
    cyc(4);
    chk("clean_miso", mi, {8'h00, ord(8'h5A)});
    chk("clean_rx", rx_log[4'(q0)], ord(8'hC3));
    chk("clean_pushes", pushes - q0, 1);
    en = 0;
    ss = 0;
    cyc(6);
    en = 1;
    cyc(6);
    chk("ss_low_at_en", active, 0);
    ss = 1;
    cyc(6);
    start(8'hFF, 8'h00, 1);
    cpol = 0;
    cpha = 0;
    ss = 0;
    cyc(8);
    sck = 1;
    cyc(4);
    chk("xfer_live", {active, miso_oe, miso}, 3'b111);
    nrst = 0;
    #1;
    chk("rst_ctl", {miso, miso_oe, tx_ren, rx_wen, active, underrun, overrun}, 0);
    chk("rst_rxdata", rx_data, 0);
    sck = 0;
    ss = 1;
    cyc(3);
    nrst = 1;
    cyc(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
